// File: rtl/lm70_spi_responder.sv
// LM70-compatible SPI responder: each CS-low frame shifts out a 16-bit temperature
// word MSB first, then takes a 16-bit command whose low byte controls shutdown.
module lm70_spi_responder #(
  parameter logic [15:0] SHDN_ID     = 16'h800F,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        SCK,
  input  logic        CS,
  input  logic        SIO_IN,
  output logic        SIO_OUT,
  output logic        SIO_OE,
  input  logic [15:0] TEMP_IN,
  output logic        SHUTDOWN,
  output logic        FRAME_DONE
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sio_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, sio_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t      state_reg, state_next;
  logic [15:0] shadow_reg, shadow_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [6:0]  cmd_reg, cmd_next;
  logic [7:0]  cmd_byte;
  logic        oe_reg, oe_next;
  logic        shdn_reg, shdn_next;
  logic        done_reg, done_next;
  logic        read_ok_reg, read_ok_next;

  // CS resets high so a frame can only begin on a genuine falling edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sio_sync <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
      sio_sync <= {sio_sync[SYNC_STAGES-2:0], SIO_IN};
      sck_d    <= sck_sync[SYNC_STAGES-1];
      cs_d     <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sio_s    = sio_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cmd_byte = {cmd_reg, sio_s};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg   <= IDLE;
      shadow_reg  <= '0;
      cnt_reg     <= '0;
      cmd_reg     <= '0;
      oe_reg      <= 1'b0;
      shdn_reg    <= 1'b0;
      done_reg    <= 1'b0;
      read_ok_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shadow_reg  <= shadow_next;
      cnt_reg     <= cnt_next;
      cmd_reg     <= cmd_next;
      oe_reg      <= oe_next;
      shdn_reg    <= shdn_next;
      done_reg    <= done_next;
      read_ok_reg <= read_ok_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (cs_fall) state_next = READ;
        READ:    if (sck_fall && cnt_reg == 4'd15) state_next = WRITE;
        WRITE:   if (sck_rise && cnt_reg == 4'd15) state_next = HOLD;
        default: state_next = state_reg;
      endcase
    end
  end

  // CS rise takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    shadow_next  = shadow_reg;
    cnt_next     = cnt_reg;
    cmd_next     = cmd_reg;
    oe_next      = oe_reg;
    shdn_next    = shdn_reg;
    done_next    = 1'b0;
    read_ok_next = read_ok_reg;
    if (cs_rise) begin
      shadow_next  = '0;
      cnt_next     = '0;
      oe_next      = 1'b0;
      done_next    = read_ok_reg;
      read_ok_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (cs_fall) begin
          shadow_next = shdn_reg ? SHDN_ID : TEMP_IN;
          cnt_next    = '0;
          oe_next     = 1'b1;
        end
        READ: if (sck_fall) begin
          shadow_next = {shadow_reg[14:0], 1'b0};
          cnt_next    = cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            oe_next      = 1'b0;
            read_ok_next = 1'b1;
          end
        end
        WRITE: if (sck_rise) begin
          cmd_next = cmd_byte[6:0];
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            if (cmd_byte == 8'hFF) shdn_next = 1'b1;
            else if (cmd_byte == 8'h00) shdn_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign SIO_OUT    = shadow_reg[15];
  assign SIO_OE     = oe_reg;
  assign SHUTDOWN   = shdn_reg;
  assign FRAME_DONE = done_reg;

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Self-checking bench: a bit-banged SPI master drives frames against a
// word-level model of the sensor's read value and shutdown flag.
module tb_lm70_spi_responder;
  localparam logic [15:0] SHDN_ID = 16'h800F;
  localparam int          SYNC    = 2;
  localparam int          PH      = 6;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        SCK = 1'b0;
  logic        CS = 1'b1;
  logic        SIO_IN = 1'b0;
  logic        SIO_OUT, SIO_OE, SHUTDOWN, FRAME_DONE;
  logic [15:0] TEMP_IN = 16'h0C1F;

  int compared = 0;
  int mismatched = 0;
  int fd_count = 0;
  logic shdn_model = 1'b0;

  lm70_spi_responder #(.SHDN_ID(SHDN_ID), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCK(SCK), .CS(CS), .SIO_IN(SIO_IN),
    .SIO_OUT(SIO_OUT), .SIO_OE(SIO_OE), .TEMP_IN(TEMP_IN),
    .SHUTDOWN(SHUTDOWN), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_DONE) fd_count <= fd_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // nrd read bits (16 = full), then nwr command bits; optional TEMP_IN change mid-read.
  task automatic run_frame(input int nrd, input int nwr, input logic [15:0] cmd,
                           input logic chg, input logic [15:0] new_temp);
    logic [15:0] exp_word, got;
    int          fd_base;
    exp_word = shdn_model ? SHDN_ID : TEMP_IN;
    got      = '0;
    fd_base  = fd_count;
    CS = 1'b0;
    wait_clk(PH);
    for (int i = 0; i < nrd; i++) begin
      if (!SIO_OE) check("oe_during_read", 32'(SIO_OE), 32'd1);
      got[15-i] = SIO_OUT;
      if (chg && i == 7) TEMP_IN = new_temp;
      SCK = 1'b1; wait_clk(PH);
      SCK = 1'b0; wait_clk(PH);
    end
    if (nrd > 0) check("read_word", 32'(got >> (16 - nrd)), 32'(exp_word >> (16 - nrd)));
    if (nrd == 16) check("oe_after_read", 32'(SIO_OE), 32'd0);
    for (int j = 0; j < nwr; j++) begin
      SIO_IN = cmd[15-j]; wait_clk(2);
      SCK = 1'b1; wait_clk(PH);
      SCK = 1'b0; wait_clk(PH - 2);
    end
    if (nwr == 16) begin
      if (cmd[7:0] == 8'hFF) shdn_model = 1'b1;
      else if (cmd[7:0] == 8'h00) shdn_model = 1'b0;
    end
    CS = 1'b1;
    wait_clk(SYNC + 1);
    check("oe_after_cs", 32'(SIO_OE), 32'd0);
    wait_clk(PH);
    check("frame_done", 32'(fd_count - fd_base), (nrd == 16) ? 32'd1 : 32'd0);
    check("shutdown", 32'(SHUTDOWN), 32'(shdn_model));
    $display("frame rd=%0d wr=%0d cmd=%h word=%h exp=%h shdn=%0d", nrd, nwr, cmd, got, exp_word, SHUTDOWN);
  endtask

  initial begin
    logic [15:0] c;
    int          r, w;
    wait_clk(3);
    check("rst_oe", 32'(SIO_OE), 32'd0);
    check("rst_out", 32'(SIO_OUT), 32'd0);
    check("rst_shdn", 32'(SHUTDOWN), 32'd0);
    check("rst_done", 32'(FRAME_DONE), 32'd0);
    RSTN = 1'b1;
    wait_clk(4);

    TEMP_IN = 16'h0C1F;
    run_frame(16, 0, 16'h0, 1'b0, 16'h0);
    run_frame(16, 16, 16'h00FF, 1'b0, 16'h0);
    run_frame(16, 16, 16'h0000, 1'b0, 16'h0);
    run_frame(16, 0, 16'h0, 1'b0, 16'h0);
    run_frame(16, 16, 16'h1234, 1'b0, 16'h0);
    run_frame(16, 8, 16'hFFFF, 1'b0, 16'h0);
    run_frame(5, 0, 16'h0, 1'b0, 16'h0);
    run_frame(16, 0, 16'h0, 1'b1, 16'h7FFF);
    run_frame(16, 0, 16'h0, 1'b0, 16'h0);

    // Reset mid-read while in shutdown.
    run_frame(16, 16, 16'hA5FF, 1'b0, 16'h0);
    CS = 1'b0;
    wait_clk(PH);
    for (int i = 0; i < 5; i++) begin
      SCK = 1'b1; wait_clk(PH);
      SCK = 1'b0; wait_clk(PH);
    end
    RSTN = 1'b0;
    #1;
    check("midrst_oe", 32'(SIO_OE), 32'd0);
    check("midrst_shdn", 32'(SHUTDOWN), 32'd0);
    check("midrst_out", 32'(SIO_OUT), 32'd0);
    shdn_model = 1'b0;
    CS = 1'b1;
    wait_clk(4);
    RSTN = 1'b1;
    wait_clk(6);
    TEMP_IN = 16'h1A2B;
    run_frame(16, 0, 16'h0, 1'b0, 16'h0);

    for (int k = 0; k < 30; k++) begin
      TEMP_IN = 16'($urandom);
      case ($urandom_range(0, 3))
        0: c = {8'($urandom), 8'hFF};
        1: c = {8'($urandom), 8'h00};
        default: c = 16'($urandom);
      endcase
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      w = (r < 16) ? 0 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16);
      run_frame(r, w, c, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
